apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_timeout_counter.sv | 29 ++
 rtl/apb_master_bridge.sv | 94 +++++++++
 tb/tb_apb_master_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W  = 12;
    localparam int unsigned APB_WDATA_W = 8;
    localparam int unsigned APB_RDATA_W = 32;
    localparam int unsigned APB_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase wait counter; flags the wait cycle that reaches the limit.
module apb_timeout_counter
    import apb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [APB_CNT_W-1:0] limit,
    output logic                 expired
);

    logic [APB_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the waiting cycle whose increment would make the count equal the limit.
    assign expired = enable && (limit != '0) &&
                     (({1'b0, count} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB master bridge with optional ACCESS-phase timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [APB_ADDR_W-1:0]  cmd_addr,
    input  logic [APB_WDATA_W-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic [APB_RDATA_W-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [APB_ADDR_W-1:0]  PADDR,
    output logic [APB_WDATA_W-1:0] PWDATA,
    input  logic                   PREADY,
    input  logic [APB_RDATA_W-1:0] PRDATA
);

    localparam logic [APB_CNT_W-1:0] LIMIT = TIMEOUT_CYCLES[APB_CNT_W-1:0];

    apb_state_e state;
    logic       expired;

    apb_timeout_counter u_timeout (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !PREADY),
        .limit   (LIMIT),
        .expired (expired)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout landing in the same cycle.
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end else if (expired) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench: driver pushes expected responses, monitor pops and compares on rsp_valid.
module tb_apb_master_bridge;

    localparam int unsigned TO = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA;
    logic [31:0] PRDATA;

    apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        int unsigned w;
        logic [31:0] prdata;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        write;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // APB slave: w wait states then PREADY with the planned data; checks address stability.
    plan_t       cur;
    int unsigned acc = 0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc    = 0;
            PREADY = 1'b0;
        end else if (PSEL && PENABLE) begin
            if (acc == 0) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                    cur = '{w: 0, prdata: 32'h0, addr: PADDR, wdata: PWDATA, write: PWRITE};
                end else begin
                    cur = plan_q.pop_front();
                end
            end
            chk("access_paddr", 32'(PADDR), 32'(cur.addr));
            chk("access_pwdata", 32'(PWDATA), 32'(cur.wdata));
            chk("access_pwrite", 32'(PWRITE), 32'(cur.write));
            PREADY = (acc == cur.w);
            PRDATA = PREADY ? cur.prdata : $urandom();
            acc++;
        end else begin
            if (PSEL) begin
                if (plan_q.size() == 0) chk("unexpected_setup", 1, 0);
                else chk("setup_paddr", 32'(PADDR), 32'(plan_q[plan_q.size()-1].addr));
            end
            acc    = 0;
            PREADY = 1'($urandom_range(0, 1));
            PRDATA = $urandom();
        end
        if (PRESETn && PSEL) begin
            chk("busy_in_xfer", 32'(busy), 1);
            chk("ready_in_xfer", 32'(cmd_ready), 0);
        end
    end

    // Response monitor
    exp_t        e;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            last_err   = 1'b0;
            last_rdata = 32'h0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cycle", cyc, e.cyc);
                last_err   = e.err;
                last_rdata = e.rdata;
            end
        end else begin
            chk("hold_err", 32'(rsp_err), 32'(last_err));
            chk("hold_rdata", rsp_rdata, last_rdata);
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with cmd_valid still high.
    task automatic send(input logic wr, input logic [11:0] addr, input logic [7:0] wd,
                        input int unsigned w, input logic [31:0] prd, input int unsigned gap);
        int          n = 0;
        int unsigned a;
        exp_t        x;
        plan_t       p;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (!cmd_ready && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_wait", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        a = cyc + 1;
        if (gap != 0) chk("accept_gap", a - last_acc, gap);
        last_acc = a;
        x.err   = (w >= TO);
        x.rdata = (x.err || wr) ? 32'h0 : prd;
        x.cyc   = x.err ? a + 1 + TO : a + 2 + w;
        exp_q.push_back(x);
        p = '{w: w, prdata: prd, addr: addr, wdata: wd, write: wr};
        plan_q.push_back(p);
        @(negedge PCLK);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom());
        cmd_addr  = 12'($urandom());
        cmd_wdata = 8'($urandom());
        @(negedge PCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        PRESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #1 PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        #2 PRESETn = 1'b1;
        @(negedge PCLK);

        // Zero-wait write, 4-wait read, timeout then immediately-accepted follow-up
        send(1'b1, 12'h104, 8'hA5, 0, 32'hDEAD_BEEF, 0);
        idle();
        send(1'b0, 12'h2C0, 8'h00, 4, 32'h0000_005A, 0);
        idle();
        send(1'b0, 12'h3F0, 8'h11, 1000, 32'h1234_5678, 0);
        send(1'b1, 12'h055, 8'h3C, 0, 32'h0, TO + 2);
        idle();
        // PREADY on the very cycle the timeout would fire, then one wait past it
        send(1'b0, 12'h7A1, 8'h00, TO - 1, 32'hCAFE_0001, 0);
        idle();
        send(1'b0, 12'h7A2, 8'h00, TO, 32'hCAFE_0002, 0);
        idle();

        // Back-to-back with cmd_valid held, then a pulse during SETUP
        send(1'b1, 12'h010, 8'h01, 0, 32'h0, 0);
        send(1'b0, 12'h020, 8'h02, 0, 32'hA0A0_0002, 3);
        send(1'b1, 12'h030, 8'h03, 0, 32'h0, 3);
        cmd_addr = 12'hFFF;
        @(negedge PCLK);
        idle();
        idle();

        // Reset while PENABLE is high
        send(1'b0, 12'h456, 8'h00, 1000, 32'h1111_2222, 0);
        idle();
        chk("pre_rst_penable", 32'(PENABLE), 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_psel", 32'(PSEL), 0);
        chk("async_penable", 32'(PENABLE), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_paddr", 32'(PADDR), 0);
        exp_q.delete();
        plan_q.delete();
        repeat (2) begin
            @(negedge PCLK);
            chk("rst_no_rsp", 32'(rsp_valid), 0);
        end
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int unsigned w;
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 3)
                                             : $urandom_range(0, 5);
            send(1'($urandom()), 12'($urandom()), 8'($urandom()), w, $urandom(), 0);
            if ($urandom_range(0, 1) == 1) @(negedge PCLK);
            repeat ($urandom_range(1, 2)) idle();
        end

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain_rsp", exp_q.size(), 0);
        chk("drain_plan", plan_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
